// File: rtl/dac_tx_pkg.sv
// Shared constants and the saturate/format helper for the HSMC DAC transmit path.
package dac_tx_pkg;

    localparam int DAC_W   = 14;
    localparam int DAC_MAX = 8191;
    localparam int DAC_MIN = -8192;
    localparam logic [DAC_W-1:0] MIDSCALE_OB = 14'h2000;

    // Callers sign-extend their sample to 32 bits, so one helper serves any DATA_W up to 32.
    function automatic logic [DAC_W-1:0] sat_fmt(input logic signed [31:0] data,
                                                 input logic               offset_bin);
        logic [DAC_W-1:0] code;
        if (data > DAC_MAX)
            code = DAC_W'(DAC_MAX);
        else if (data < DAC_MIN)
            code = DAC_W'(DAC_MIN);
        else
            code = data[DAC_W-1:0];
        if (offset_bin)
            code[DAC_W-1] = ~code[DAC_W-1];
        return code;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with registered full/empty/fill and a registered write-ready.
module sync_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fill
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              full;
    logic              do_wr;
    logic              do_rd;
    logic [CW-1:0]     fill_nxt;

    // wr_ready is low during reset and equals !full afterwards, so a full FIFO never takes a write.
    assign do_wr   = wr_en && wr_ready && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        fill_nxt = fill;
        if (do_wr && !do_rd)
            fill_nxt = fill + CW'(1);
        else if (do_rd && !do_wr)
            fill_nxt = fill - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            wr_ready <= 1'b0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_rd)
                rd_ptr <= rd_ptr + AW'(1);
            fill     <= fill_nxt;
            full     <= (fill_nxt == CW'(FIFO_DEPTH));
            empty    <= (fill_nxt == '0);
            wr_ready <= (fill_nxt != CW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/hsmc_dac_tx.sv
// One HSMC DAC channel: FIFO-buffered samples released once per update period, saturated, formatted, strobed.
// Optional DAC_TX_TEST_PATTERN_EN adds a test_en input that replaces FIFO samples with a 14-bit ramp.
module hsmc_dac_tx #(
    parameter int DATA_W     = 16,
    parameter int DAC_W      = 14,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [11:0]                   rate,
    input  logic                          offset_bin,
    input  logic                          clr_uflow,
`ifdef DAC_TX_TEST_PATTERN_EN
    input  logic                          test_en,
`endif
    input  logic [DATA_W-1:0]             s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [DAC_W-1:0]              dac_data,
    output logic                          dac_wrt,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic                          uflow,
    output logic [15:0]                   uflow_cnt
);

    import dac_tx_pkg::*;

    logic [11:0]              cnt;
    logic [11:0]              r_eff;
    logic [11:0]              r_last;
    logic [11:0]              r_half;
    logic                     tick;
    logic                     pattern;
    logic                     pop;
    logic                     uflow_evt;
    logic                     empty;
    logic signed [DATA_W-1:0] head;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (s_valid),
        .wr_data  (s_data),
        .wr_ready (s_ready),
        .rd_en    (pop),
        .rd_data  (head),
        .empty    (empty),
        .fill     (fill)
    );

`ifdef DAC_TX_TEST_PATTERN_EN
    logic [DAC_W-1:0] ramp;
    assign pattern = test_en;
`else
    assign pattern = 1'b0;
`endif

    // Periods below 2 would leave no room for the mid-period strobe, so they clamp to 2.
    assign r_eff  = (rate < 12'd2) ? 12'd2 : rate;
    assign r_last = r_eff - 12'd1;
    assign r_half = (r_eff >> 1) - 12'd1;

    // ">=" rather than "==" so a rate cut below the current count ticks on the very next edge.
    assign tick      = en && (cnt >= r_last);
    assign pop       = tick && !empty && !pattern;
    assign uflow_evt = tick && empty && !pattern;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            dac_data  <= offset_bin ? DAC_W'(MIDSCALE_OB) : '0;
            dac_wrt   <= 1'b0;
            uflow     <= 1'b0;
            uflow_cnt <= '0;
`ifdef DAC_TX_TEST_PATTERN_EN
            ramp      <= '0;
`endif
        end else begin
            // Strobe falls with each data update and rises mid-period, centring the DAC latch edge.
            if (!en) begin
                cnt     <= '0;
                dac_wrt <= 1'b0;
            end else if (tick) begin
                cnt     <= '0;
                dac_wrt <= 1'b0;
            end else begin
                cnt <= cnt + 12'd1;
                if (cnt == r_half)
                    dac_wrt <= 1'b1;
            end

            if (pop)
                dac_data <= DAC_W'(sat_fmt(32'(head), offset_bin));
`ifdef DAC_TX_TEST_PATTERN_EN
            if (tick && test_en) begin
                ramp     <= ramp + DAC_W'(1);
                dac_data <= ramp + DAC_W'(1);
            end
`endif

            // A clear coinciding with an underflow tick wins; that underflow is not recorded.
            if (clr_uflow) begin
                uflow     <= 1'b0;
                uflow_cnt <= '0;
            end else if (uflow_evt) begin
                uflow <= 1'b1;
                if (uflow_cnt != 16'hFFFF)
                    uflow_cnt <= uflow_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hsmc_dac_tx.sv
// Directed, table-driven bench for hsmc_dac_tx with hand-computed expected codes and timing.
module tb_hsmc_dac_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [11:0] rate = 12'd4;
    logic        offset_bin = 1'b0;
    logic        clr_uflow = 1'b0;
    logic        test_en = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [13:0] dac_data;
    logic        dac_wrt;
    logic [4:0]  fill;
    logic        uflow;
    logic [15:0] uflow_cnt;

    int checks = 0;
    int errors = 0;

    hsmc_dac_tx #(
        .DATA_W     (16),
        .DAC_W      (14),
        .FIFO_DEPTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .rate       (rate),
        .offset_bin (offset_bin),
        .clr_uflow  (clr_uflow),
`ifdef DAC_TX_TEST_PATTERN_EN
        .test_en    (test_en),
`endif
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .dac_data   (dac_data),
        .dac_wrt    (dac_wrt),
        .fill       (fill),
        .uflow      (uflow),
        .uflow_cnt  (uflow_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        ob;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Leaves the bench 1 time unit after the last reset edge ("S0").
    task automatic do_reset(input logic ob);
        s_valid    = 1'b0;
        clr_uflow  = 1'b0;
        offset_bin = ob;
        rst        = 1'b1;
        step(2);
        rst        = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] smp[17];

    initial begin
        vecs[0]  = '{16'h0100, 1'b0, 14'h0100};
        vecs[1]  = '{16'h7FFF, 1'b0, 14'h1FFF};
        vecs[2]  = '{16'h8000, 1'b0, 14'h2000};
        vecs[3]  = '{16'hFF00, 1'b0, 14'h3F00};
        vecs[4]  = '{16'h0100, 1'b1, 14'h2100};
        vecs[5]  = '{16'h7FFF, 1'b1, 14'h3FFF};
        vecs[6]  = '{16'h8000, 1'b1, 14'h0000};
        vecs[7]  = '{16'hFF00, 1'b1, 14'h1F00};
        vecs[8]  = '{16'h1FFF, 1'b0, 14'h1FFF};
        vecs[9]  = '{16'h2000, 1'b0, 14'h1FFF};
        vecs[10] = '{16'hE000, 1'b0, 14'h2000};
        vecs[11] = '{16'hDFFF, 1'b0, 14'h2000};
        vecs[12] = '{16'h0000, 1'b1, 14'h2000};
        for (int i = 0; i < 17; i++)
            smp[i] = 16'(i * 37 + 5);

        // Reset state and free-running underflow with no data.
        rate = 12'd4;
        en   = 1'b1;
        do_reset(1'b1);
        chk("rst_dac_data", 32'(dac_data), 32'h2000);
        chk("rst_s_ready", 32'(s_ready), 32'h0);
        chk("rst_fill", 32'(fill), 32'h0);
        chk("rst_uflow", 32'(uflow), 32'h0);
        chk("rst_uflow_cnt", 32'(uflow_cnt), 32'h0);
        chk("rst_dac_wrt", 32'(dac_wrt), 32'h0);
        step(1);
        chk("s1_s_ready", 32'(s_ready), 32'h1);
        chk("s1_wrt", 32'(dac_wrt), 32'h0);
        step(1);
        chk("s2_wrt", 32'(dac_wrt), 32'h1);
        step(1);
        chk("s3_uflow", 32'(uflow), 32'h0);
        step(1);
        chk("s4_uflow", 32'(uflow), 32'h1);
        chk("s4_wrt", 32'(dac_wrt), 32'h0);
        step(2);
        chk("s6_wrt", 32'(dac_wrt), 32'h1);
        step(6);
        chk("s12_uflow_cnt", 32'(uflow_cnt), 32'd3);
        chk("s12_dac_hold", 32'(dac_data), 32'h2000);

        // Saturation and format vectors: one sample each, popped on the first tick.
        for (int v = 0; v < 13; v++) begin
            rate = 12'd4;
            en   = 1'b1;
            do_reset(vecs[v].ob);
            step(1);
            s_valid = 1'b1;
            s_data  = vecs[v].data;
            step(1);
            s_valid = 1'b0;
            step(2);
            chk($sformatf("vec%0d_code", v), 32'(dac_data), 32'(vecs[v].exp));
        end

        // Back-to-back pushes: one sample released every 4 cycles, strobe 2 cycles after each update.
        rate = 12'd4;
        en   = 1'b1;
        do_reset(1'b0);
        step(1);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = vecs[i].data;
            step(1);
        end
        s_valid = 1'b0;
        chk("b2b_d0", 32'(dac_data), 32'h0100);
        chk("b2b_wrt_lo", 32'(dac_wrt), 32'h0);
        step(1);
        chk("b2b_wrt_hi", 32'(dac_wrt), 32'h1);
        step(2);
        chk("b2b_d1", 32'(dac_data), 32'h1FFF);
        step(4);
        chk("b2b_d2", 32'(dac_data), 32'h2000);
        step(4);
        chk("b2b_d3", 32'(dac_data), 32'h3F00);
        chk("b2b_uflow", 32'(uflow), 32'h0);
        chk("b2b_fill", 32'(fill), 32'h0);

        // FIFO full: 17 samples with s_valid held; the 17th waits for the first pop.
        rate = 12'd10;
        en   = 1'b0;
        do_reset(1'b0);
        step(1);
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data  = smp[i];
            step(1);
        end
        s_data = smp[16];
        chk("full_fill", 32'(fill), 32'd16);
        chk("full_s_ready", 32'(s_ready), 32'h0);
        chk("full_dac_hold", 32'(dac_data), 32'h0);
        en = 1'b1;
        step(9);
        chk("full_wait_ready", 32'(s_ready), 32'h0);
        chk("full_wait_fill", 32'(fill), 32'd16);
        step(1);
        chk("full_pop0", 32'(dac_data), 32'(smp[0][13:0]));
        chk("full_ready_again", 32'(s_ready), 32'h1);
        chk("full_fill15", 32'(fill), 32'd15);
        step(1);
        s_valid = 1'b0;
        chk("full_refill", 32'(fill), 32'd16);
        for (int j = 1; j < 17; j++) begin
            step(j == 1 ? 9 : 10);
            chk($sformatf("drain%0d", j), 32'(dac_data), 32'(smp[j][13:0]));
        end
        chk("drain_uflow", 32'(uflow), 32'h0);
        chk("drain_fill", 32'(fill), 32'h0);

        // Rate cut below the running count, then rate=1 clamped to a period of 2.
        rate = 12'd20;
        en   = 1'b1;
        do_reset(1'b0);
        step(15);
        chk("rc_pre", 32'(uflow_cnt), 32'd0);
        rate = 12'd3;
        step(1);
        chk("rc_next", 32'(uflow_cnt), 32'd1);
        step(1);
        chk("rc_r3_wrt", 32'(dac_wrt), 32'h1);
        step(1);
        chk("rc_r3_hold", 32'(uflow_cnt), 32'd1);
        step(1);
        chk("rc_r3_t2", 32'(uflow_cnt), 32'd2);
        step(3);
        chk("rc_r3_t3", 32'(uflow_cnt), 32'd3);
        rate = 12'd1;
        step(1);
        chk("rc_r1_wrt_hi", 32'(dac_wrt), 32'h1);
        step(1);
        chk("rc_r1_t4", 32'(uflow_cnt), 32'd4);
        chk("rc_r1_wrt_lo", 32'(dac_wrt), 32'h0);
        step(1);
        chk("rc_r1_hold", 32'(uflow_cnt), 32'd4);
        step(1);
        chk("rc_r1_t5", 32'(uflow_cnt), 32'd5);

        // Disabled channel still buffers; then mid-stream reset.
        rate = 12'd4;
        en   = 1'b0;
        do_reset(1'b0);
        step(1);
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = vecs[i].data;
            step(1);
        end
        s_valid = 1'b0;
        step(10);
        chk("dis_fill", 32'(fill), 32'd5);
        chk("dis_dac", 32'(dac_data), 32'h0);
        chk("dis_uflow", 32'(uflow_cnt), 32'd0);
        chk("dis_wrt", 32'(dac_wrt), 32'h0);
        en = 1'b1;
        step(4);
        chk("en_first_pop", 32'(dac_data), 32'h0100);
        chk("en_fill", 32'(fill), 32'd4);
        offset_bin = 1'b1;
        rst        = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mrst_fill", 32'(fill), 32'd0);
        chk("mrst_dac", 32'(dac_data), 32'h2000);
        chk("mrst_ready", 32'(s_ready), 32'h0);

        // clr_uflow on an underflow tick: the clear wins.
        step(4);
        chk("clr_pre", 32'(uflow_cnt), 32'd1);
        step(3);
        clr_uflow = 1'b1;
        step(1);
        clr_uflow = 1'b0;
        chk("clr_cnt", 32'(uflow_cnt), 32'd0);
        chk("clr_flag", 32'(uflow), 32'h0);
        step(4);
        chk("clr_after", 32'(uflow_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
